// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic units: FSM encoding and default width.
package serial_arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      StIdle  = ST_IDLE,
      StShift = ST_SHIFT,
      StDone  = ST_DONE
   } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, zero
   );
endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one full-subtractor step per clock behind a start/busy/done
// handshake. Results are registered on entry to DONE and held until the next DONE.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                clk,
   input logic                nrst,
   serial_subtractor_if.slave bus
);
   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_next;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             bff_q, bff_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             zero_q, zero_d;
   logic             cell_d, cell_bout;

   full_subtractor u_cell (
      .x    (a_sr_q[0]),
      .y    (b_sr_q[0]),
      .bin  (bff_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         bff_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         bff_q    <= bff_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      bff_d    = bff_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      // Result register fills from the MSB so the first bit computed ends up at bit 0.
      res_next = {cell_d, res_q[WIDTH-1:1]};

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               bff_d   = 1'b0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            res_d  = res_next;
            bff_d  = cell_bout;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d  = StDone;
               diff_d   = res_next;
               borrow_d = cell_bout;
               zero_d   = (res_next == '0);
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
   assign bus.zero   = zero_q;

endmodule
